// File: rtl/ll_pkg.sv
// ll_pkg: shared widths and types for the linked-list next-pointer arbiter.
//   PTR_WD   : width of node position and pointer fields
//   t_arb_st : arbiter FSM states (IDLE, WAIT_RSP)
//   t_owner  : which requester owns the nxt_ptr_logic port (OWN_WR, OWN_RD)
package ll_pkg;
    localparam int PTR_WD = 8;
    typedef enum logic {IDLE, WAIT_RSP} t_arb_st;
    typedef enum logic {OWN_WR, OWN_RD} t_owner;
endpackage

// File: rtl/ll_nxt_ptr_arb_if.sv
// ll_nxt_ptr_arb_if: bus bundle between the write/read controllers, the arbiter and nxt_ptr_logic.
//   wr_* / rd_*      : requester side (req_vld, req_pop, node_at_pos in; gnt, rsp_vld, rsp_data out)
//   *_to_nxt_ptr     : launch pulse and payload towards nxt_ptr_logic
//   nxt_ptr_rsp_*    : response from nxt_ptr_logic
//   arb_busy         : transaction outstanding
//   arb_timeout_err  : watchdog error pulse
//   modport slave    : arbiter view; modport master : environment view
interface ll_nxt_ptr_arb_if;
    import ll_pkg::*;
    logic              wr_req_vld;
    logic              wr_req_pop;
    logic [PTR_WD-1:0] wr_node_at_pos;
    logic              wr_gnt;
    logic              wr_rsp_vld;
    logic [PTR_WD-1:0] wr_rsp_data;
    logic              rd_req_vld;
    logic              rd_req_pop;
    logic [PTR_WD-1:0] rd_node_at_pos;
    logic              rd_gnt;
    logic              rd_rsp_vld;
    logic [PTR_WD-1:0] rd_rsp_data;
    logic              req_vld_to_nxt_ptr;
    logic              req_pop_to_nxt_ptr;
    logic              req_wr_to_nxt_ptr;
    logic [PTR_WD-1:0] node_at_pos_to_nxt_ptr;
    logic              nxt_ptr_rsp_vld;
    logic [PTR_WD-1:0] nxt_ptr_rsp_data;
    logic              arb_busy;
    logic              arb_timeout_err;

    modport slave (
        input  wr_req_vld, wr_req_pop, wr_node_at_pos,
        input  rd_req_vld, rd_req_pop, rd_node_at_pos,
        input  nxt_ptr_rsp_vld, nxt_ptr_rsp_data,
        output wr_gnt, wr_rsp_vld, wr_rsp_data,
        output rd_gnt, rd_rsp_vld, rd_rsp_data,
        output req_vld_to_nxt_ptr, req_pop_to_nxt_ptr, req_wr_to_nxt_ptr, node_at_pos_to_nxt_ptr,
        output arb_busy, arb_timeout_err
    );

    modport master (
        output wr_req_vld, wr_req_pop, wr_node_at_pos,
        output rd_req_vld, rd_req_pop, rd_node_at_pos,
        output nxt_ptr_rsp_vld, nxt_ptr_rsp_data,
        input  wr_gnt, wr_rsp_vld, wr_rsp_data,
        input  rd_gnt, rd_rsp_vld, rd_rsp_data,
        input  req_vld_to_nxt_ptr, req_pop_to_nxt_ptr, req_wr_to_nxt_ptr, node_at_pos_to_nxt_ptr,
        input  arb_busy, arb_timeout_err
    );
endinterface

// File: rtl/ll_rr_arb2.sv
// ll_rr_arb2: combinational 2-way round-robin picker.
//   req_wr, req_rd : requests
//   last_owner     : previous grant owner; the other side wins a tie
//   winner         : selected side (only meaningful when any_req)
//   any_req        : at least one request present
module ll_rr_arb2
    import ll_pkg::*;
(
    input  logic   req_wr,
    input  logic   req_rd,
    input  t_owner last_owner,
    output t_owner winner,
    output logic   any_req
);
    assign any_req = req_wr | req_rd;
    assign winner  = (req_wr && (!req_rd || last_owner == OWN_RD)) ? OWN_WR : OWN_RD;
endmodule

// File: rtl/ll_nxt_ptr_arb.sv
// ll_nxt_ptr_arb: shares the single nxt_ptr_logic port between write and read controllers.
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : ll_nxt_ptr_arb_if.slave (requests, grants, launch, response routing, status)
// One outstanding transaction at a time, round-robin on ties, all outputs registered.
// Optional response watchdog enabled by defining LL_NXT_PTR_ARB_TIMEOUT_EN
// (parameter TIMEOUT_CYC, default 64); without it arb_timeout_err is tied 0.
module ll_nxt_ptr_arb
    import ll_pkg::*;
`ifdef LL_NXT_PTR_ARB_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYC = 64
)
`endif
(
    input logic              clk,
    input logic              reset_n,
    ll_nxt_ptr_arb_if.slave  bus
);
    t_arb_st           state_q, state_d;
    t_owner            owner_q, owner_d, winner;
    logic              any_req, launch, done, expire, win_wr, own_wr;
    logic              wr_gnt_d, rd_gnt_d, pop_d, req_wr_d, wr_rsp_vld_d, rd_rsp_vld_d;
    logic [PTR_WD-1:0] node_d, rsp_data, wr_rsp_data_d, rd_rsp_data_d;

    ll_rr_arb2 u_pick (
        .req_wr     (bus.wr_req_vld),
        .req_rd     (bus.rd_req_vld),
        .last_owner (owner_q),
        .winner     (winner),
        .any_req    (any_req)
    );

`ifdef LL_NXT_PTR_ARB_TIMEOUT_EN
    localparam int CNT_WD = $clog2(TIMEOUT_CYC) + 1;
    logic [CNT_WD-1:0] cnt_q;

    assign expire = cnt_q == CNT_WD'(TIMEOUT_CYC);

    // Held at 0 in IDLE so it is already clear in the launch cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q               <= '0;
            bus.arb_timeout_err <= 1'b0;
        end else begin
            cnt_q               <= (state_q == IDLE) ? '0 : cnt_q + 1'b1;
            bus.arb_timeout_err <= done && !bus.nxt_ptr_rsp_vld;
        end
    end
`else
    assign expire              = 1'b0;
    assign bus.arb_timeout_err = 1'b0;
`endif

    always_comb begin
        launch        = state_q == IDLE && any_req;
        // A real response wins over a simultaneous watchdog expiry.
        done          = state_q == WAIT_RSP && (bus.nxt_ptr_rsp_vld || expire);
        win_wr        = winner == OWN_WR;
        own_wr        = owner_q == OWN_WR;
        state_d       = launch ? WAIT_RSP : done ? IDLE : state_q;
        owner_d       = launch ? winner : owner_q;
        wr_gnt_d      = launch && win_wr;
        rd_gnt_d      = launch && !win_wr;
        req_wr_d      = launch && win_wr;
        pop_d         = launch && (win_wr ? bus.wr_req_pop : bus.rd_req_pop);
        node_d        = !launch ? '0 : win_wr ? bus.wr_node_at_pos : bus.rd_node_at_pos;
        rsp_data      = bus.nxt_ptr_rsp_vld ? bus.nxt_ptr_rsp_data : '0;
        wr_rsp_vld_d  = done && own_wr;
        rd_rsp_vld_d  = done && !own_wr;
        wr_rsp_data_d = wr_rsp_vld_d ? rsp_data : '0;
        rd_rsp_data_d = rd_rsp_vld_d ? rsp_data : '0;
    end

    // last_owner resets to RD so the write side wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q                    <= IDLE;
            owner_q                    <= OWN_RD;
            bus.wr_gnt                 <= 1'b0;
            bus.rd_gnt                 <= 1'b0;
            bus.req_vld_to_nxt_ptr     <= 1'b0;
            bus.req_pop_to_nxt_ptr     <= 1'b0;
            bus.req_wr_to_nxt_ptr      <= 1'b0;
            bus.node_at_pos_to_nxt_ptr <= '0;
            bus.wr_rsp_vld             <= 1'b0;
            bus.wr_rsp_data            <= '0;
            bus.rd_rsp_vld             <= 1'b0;
            bus.rd_rsp_data            <= '0;
            bus.arb_busy               <= 1'b0;
        end else begin
            state_q                    <= state_d;
            owner_q                    <= owner_d;
            bus.wr_gnt                 <= wr_gnt_d;
            bus.rd_gnt                 <= rd_gnt_d;
            bus.req_vld_to_nxt_ptr     <= launch;
            bus.req_pop_to_nxt_ptr     <= pop_d;
            bus.req_wr_to_nxt_ptr      <= req_wr_d;
            bus.node_at_pos_to_nxt_ptr <= node_d;
            bus.wr_rsp_vld             <= wr_rsp_vld_d;
            bus.wr_rsp_data            <= wr_rsp_data_d;
            bus.rd_rsp_vld             <= rd_rsp_vld_d;
            bus.rd_rsp_data            <= rd_rsp_data_d;
            bus.arb_busy               <= state_d == WAIT_RSP;
        end
    end
endmodule

// File: tb/tb_ll_nxt_ptr_arb.sv
// tb_ll_nxt_ptr_arb: directed self-checking bench for ll_nxt_ptr_arb.
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point,
// so each check sees the registers loaded by the preceding edge.
module tb_ll_nxt_ptr_arb;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    ll_nxt_ptr_arb_if bus ();

`ifdef LL_NXT_PTR_ARB_TIMEOUT_EN
    ll_nxt_ptr_arb #(.TIMEOUT_CYC(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`else
    ll_nxt_ptr_arb dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
    endtask

    // one-cycle response pulse from nxt_ptr_logic; afterwards the delivery is visible
    task automatic respond(input logic [7:0] d);
        bus.nxt_ptr_rsp_vld  = 1'b1;
        bus.nxt_ptr_rsp_data = d;
        step();
        bus.nxt_ptr_rsp_vld  = 1'b0;
        bus.nxt_ptr_rsp_data = '0;
    endtask

    task automatic chk_launch(input string tag, input logic wr, input logic pop, input logic [7:0] node);
        chk({tag, "_vld"},  32'(bus.req_vld_to_nxt_ptr), 32'd1);
        chk({tag, "_wgnt"}, 32'(bus.wr_gnt), 32'(wr));
        chk({tag, "_rgnt"}, 32'(bus.rd_gnt), 32'(!wr));
        chk({tag, "_rw"},   32'(bus.req_wr_to_nxt_ptr), 32'(wr));
        chk({tag, "_pop"},  32'(bus.req_pop_to_nxt_ptr), 32'(pop));
        chk({tag, "_node"}, 32'(bus.node_at_pos_to_nxt_ptr), 32'(node));
        chk({tag, "_busy"}, 32'(bus.arb_busy), 32'd1);
    endtask

    task automatic chk_rsp(input string tag, input logic wv, input logic [7:0] wd,
                           input logic rv, input logic [7:0] rdd);
        chk({tag, "_wv"}, 32'(bus.wr_rsp_vld), 32'(wv));
        chk({tag, "_wd"}, 32'(bus.wr_rsp_data), 32'(wd));
        chk({tag, "_rv"}, 32'(bus.rd_rsp_vld), 32'(rv));
        chk({tag, "_rd"}, 32'(bus.rd_rsp_data), 32'(rdd));
    endtask

    initial begin
        bus.wr_req_vld = 0; bus.wr_req_pop = 0; bus.wr_node_at_pos = '0;
        bus.rd_req_vld = 0; bus.rd_req_pop = 0; bus.rd_node_at_pos = '0;
        bus.nxt_ptr_rsp_vld = 0; bus.nxt_ptr_rsp_data = '0;
        do_reset();

        // reset state
        chk("rst_busy", 32'(bus.arb_busy), 32'd0);
        chk("rst_launch", 32'(bus.req_vld_to_nxt_ptr), 32'd0);
        chk("rst_gnt", {bus.wr_gnt, bus.rd_gnt}, 32'd0);
        chk("rst_err", 32'(bus.arb_timeout_err), 32'd0);
        chk_rsp("rst", 0, 8'h00, 0, 8'h00);

        // single write request
        bus.wr_req_vld = 1; bus.wr_node_at_pos = 8'h05; bus.wr_req_pop = 0;
        step();
        chk_launch("t1_l", 1, 0, 8'h05);
        bus.wr_req_vld = 0; bus.wr_node_at_pos = '0;
        step();
        chk("t1_vld_off", 32'(bus.req_vld_to_nxt_ptr), 32'd0);
        chk("t1_gnt_off", 32'(bus.wr_gnt), 32'd0);
        chk("t1_node_off", 32'(bus.node_at_pos_to_nxt_ptr), 32'd0);
        chk("t1_busy", 32'(bus.arb_busy), 32'd1);
        step();
        respond(8'h2A);
        chk_rsp("t1_r", 1, 8'h2A, 0, 8'h00);
        chk("t1_idle", 32'(bus.arb_busy), 32'd0);
        step();
        chk_rsp("t1_r2", 0, 8'h00, 0, 8'h00);

        // both requesting from reset: alternation over four transactions
        do_reset();
        bus.wr_req_vld = 1; bus.wr_req_pop = 1; bus.wr_node_at_pos = 8'h11;
        bus.rd_req_vld = 1; bus.rd_req_pop = 1; bus.rd_node_at_pos = 8'h03;
        step();
        chk_launch("t2a", 1, 1, 8'h11);
        bus.wr_req_vld = 0;
        respond(8'h33);
        chk_rsp("t2a_r", 1, 8'h33, 0, 8'h00);
        bus.wr_req_vld = 1; bus.wr_req_pop = 0; bus.wr_node_at_pos = 8'h22;
        step();
        chk_launch("t2b", 0, 1, 8'h03);
        bus.rd_req_vld = 0;
        respond(8'h44);
        chk_rsp("t2b_r", 0, 8'h00, 1, 8'h44);
        bus.rd_req_vld = 1; bus.rd_req_pop = 0; bus.rd_node_at_pos = 8'h07;
        step();
        chk_launch("t2c", 1, 0, 8'h22);
        bus.wr_req_vld = 0;
        respond(8'h55);
        chk_rsp("t2c_r", 1, 8'h55, 0, 8'h00);
        step();
        chk_launch("t2d", 0, 0, 8'h07);
        bus.rd_req_vld = 0;
        respond(8'h66);
        chk_rsp("t2d_r", 0, 8'h00, 1, 8'h66);

        // request held during WAIT_RSP, then a stray response in IDLE
        step();
        bus.wr_req_vld = 1; bus.wr_req_pop = 0; bus.wr_node_at_pos = 8'h09;
        step();
        chk_launch("t3", 1, 0, 8'h09);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_nolaunch", {bus.req_vld_to_nxt_ptr, bus.wr_gnt, bus.rd_gnt}, 32'd0);
        end
        bus.wr_req_vld = 0;
        respond(8'h12);
        chk_rsp("t3_r", 1, 8'h12, 0, 8'h00);
        step();
        respond(8'h77);
        chk_rsp("t3_stray", 0, 8'h00, 0, 8'h00);
        chk("t3_stray_busy", 32'(bus.arb_busy), 32'd0);
        chk("t3_stray_launch", 32'(bus.req_vld_to_nxt_ptr), 32'd0);

        // async reset while a read transaction is outstanding
        bus.rd_req_vld = 1; bus.rd_req_pop = 1; bus.rd_node_at_pos = 8'h0A;
        step();
        chk_launch("t4", 0, 1, 8'h0A);
        bus.rd_req_vld = 0;
        reset_n = 1'b0;
        #1;
        chk("t4_async_launch", 32'(bus.req_vld_to_nxt_ptr), 32'd0);
        chk("t4_async_gnt", 32'(bus.rd_gnt), 32'd0);
        chk("t4_async_busy", 32'(bus.arb_busy), 32'd0);
        chk("t4_async_node", 32'(bus.node_at_pos_to_nxt_ptr), 32'd0);
        step();
        reset_n = 1'b1;
        respond(8'h88);
        chk_rsp("t4_drop", 0, 8'h00, 0, 8'h00);
        bus.wr_req_vld = 1; bus.wr_req_pop = 0; bus.wr_node_at_pos = 8'h01;
        bus.rd_req_vld = 1; bus.rd_req_pop = 1; bus.rd_node_at_pos = 8'h02;
        step();
        chk_launch("t4_tie", 1, 0, 8'h01);
        bus.wr_req_vld = 0; bus.rd_req_vld = 0;
        respond(8'h99);
        chk_rsp("t4_r", 1, 8'h99, 0, 8'h00);
        step();

        // watchdog
        bus.wr_req_vld = 1; bus.wr_req_pop = 1; bus.wr_node_at_pos = 8'h0C;
        step();
        chk_launch("t5", 1, 1, 8'h0C);
        bus.wr_req_vld = 0;
`ifdef LL_NXT_PTR_ARB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t5_wait_err", 32'(bus.arb_timeout_err), 32'd0);
            chk("t5_wait_rsp", 32'(bus.wr_rsp_vld), 32'd0);
        end
        step();
        chk("t5_err", 32'(bus.arb_timeout_err), 32'd1);
        chk_rsp("t5_to", 1, 8'h00, 0, 8'h00);
        chk("t5_busy", 32'(bus.arb_busy), 32'd0);
        step();
        chk("t5_err_off", 32'(bus.arb_timeout_err), 32'd0);
        respond(8'hAB);
        chk_rsp("t5_late", 0, 8'h00, 0, 8'h00);
`else
        for (int i = 0; i < 100; i++) begin
            step();
            chk("t5_busy_hold", {bus.arb_busy, bus.arb_timeout_err, bus.wr_rsp_vld}, 32'b100);
        end
        respond(8'hAB);
        chk_rsp("t5_r", 1, 8'hAB, 0, 8'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
